tldd_seq: RTL and testbench
===========================

# tldd_seq

Parametrised multi-channel laser-diode pulse sequencer, the next generation of the single-shot LDD pulse generator. On a trigger it drives a masked set of CH_NUM channel outputs with programmable pulse width and gap, in single-shot, N-pulse burst or free-running continuous mode. It reports a completion pulse, a missed-trigger pulse and a pulse count. It sits in the 200 MHz domain between the capture sync logic and the LVDS output buffers, which are external to this block.

## Interface
- CH_NUM, 3: number of laser channels.
- CNT_W, 32: width of pulse/gap length fields.
- BURST_W, 8: width of burst count and pulse counter.

- clki  in  1  sequencer clock, all logic on rising edge.
- rsti_n  in  1  asynchronous, active-low reset.
- en  in  1  block enable; low aborts any sequence immediately.
- mode  in  2  mode select: 0 off, 1 single-shot, 2 burst, 3 continuous.
- ch_mask  in  CH_NUM  channels driven during a sequence.
- plus_len  in  CNT_W  pulse high time in cycles; 0 treated as 1.
- gap_len  in  CNT_W  low time between pulses in cycles; 0 treated as 1.
- burst_num  in  BURST_W  pulses per burst; 0 treated as 1.
- trig  in  1  trigger level, synchronous to clki; the rising edge starts a sequence.
- ldd_out  out  CH_NUM  registered pulse outputs.
- busy  out  1  high while a sequence runs.
- rdy  out  1  one-cycle pulse on normal completion.
- trig_miss  out  1  one-cycle pulse when a trigger edge arrives while busy.
- pulse_cnt  out  BURST_W  pulses emitted in the current or last sequence.

## Operation
- Reset values: ldd_out=0, busy=0, rdy=0, trig_miss=0, pulse_cnt=0, state IDLE, trig_d=0.
- Edge detect: trig_edge = trig & !trig_d, where trig_d is a one-register delay.
- FSM states: IDLE, PULSE, GAP.
- IDLE→PULSE on either of:
  - trig_edge & en & mode∈{1,2}; or
  - en & mode==3, with no trigger needed.
- On entry to PULSE from IDLE:
  - shadow-latch ch_mask, plus_len, gap_len, burst_num and mode;
  - set pulse_cnt to 1.
- PULSE:
  - ldd_out = shadow ch_mask; the phase counter loads len-1 and counts down.
  - At 0, go to IDLE if the sequence is done, else go to GAP.
- Sequence done when any of:
  - shadow mode is 1;
  - shadow mode is 2 and pulse_cnt == burst_num (0 treated as 1);
  - shadow mode is 3 and live mode≠3.
- GAP: ldd_out = 0. At 0, go to PULSE and increment pulse_cnt, wrapping at 2^BURST_W.
- Continuous stop: a change of live mode away from 3 never truncates a pulse; the current PULSE completes.
  - If the change occurs during GAP, the sequence ends at the end of that GAP.
- Live inputs changing mid-sequence have no effect, except live mode when running in continuous mode.
- en low in any state: next cycle returns to IDLE with ldd_out=0 and busy=0. No rdy is issued; pulse_cnt holds.
- rdy: asserted for one cycle on a normal PULSE/GAP→IDLE transition.
- trig_miss: issued when trig_edge occurs while busy=1. A trig_edge with en=0 or mode∈{0,3} is ignored silently.
- ch_mask=0: the sequence runs with full timing, rdy and pulse_cnt, but all outputs stay low.
- Asynchronous reset mid-sequence: all outputs clear immediately on assertion.

## Timing
- trig high at edge N with trig_d=0 → ldd_out high during cycles N+1 … N+plus_len. busy rises at N+1.
- Gap: ldd_out low for exactly gap_len cycles between consecutive pulses.
- Completion: at cycle M+1 after the last high cycle M, ldd_out=0, busy=0 and rdy=1.
  - A trig_edge at M+1 is accepted; its pulse starts at M+2.
- trig_miss is asserted in the cycle after the offending edge.
- Burst length is plus_len·B + gap_len·(B−1) cycles for B pulses.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package tldd_pkg holds:
  - the state enum (IDLE, PULSE, GAP);
  - the mode constants (MODE_OFF, MODE_SINGLE, MODE_BURST, MODE_CONT).
- One sub-module, tldd_phase_cnt: a CNT_W down-counter with load, zero-substitution (0→1) and a terminal flag. It is shared by PULSE and GAP.

## Test plan
- Single-shot, plus_len=5, ch_mask=3'b101, trig edge at cycle 10:
  - ldd_out=101 for cycles 11–15;
  - rdy at 16, pulse_cnt=1, busy high 11–15.
- Burst, burst_num=3, plus_len=2, gap_len=4:
  - pulses at 11–12, 17–18 and 23–24;
  - rdy at 25, pulse_cnt=3.
  - A second trig edge at cycle 14 gives trig_miss at 15, and the burst is unaffected.
- Continuous, plus_len=1, gap_len=1:
  - toggling output with pulse_cnt incrementing;
  - with BURST_W=8, pulse_cnt wraps 255→0;
  - mode→1 mid-PULSE finishes that pulse, then rdy.
- en dropped during the second pulse of a burst:
  - ldd_out=0 and busy=0 next cycle, no rdy, pulse_cnt=2.
- Zero lengths, plus_len=0, gap_len=0, burst_num=0, mode 2: exactly one 1-cycle pulse, then rdy.
- rsti_n asserted mid-pulse: outputs clear asynchronously. After release a new trig edge gives a normal pulse.

Source files
------------

// File: rtl/tldd_pkg.sv
// Shared types and constants for the tldd_seq pulse sequencer.
package tldd_pkg;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPulse = 2'd1,
        StGap   = 2'd2
    } state_e;

    // Mode select encodings.
    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_SINGLE = 2'd1;
    localparam logic [1:0] MODE_BURST  = 2'd2;
    localparam logic [1:0] MODE_CONT   = 2'd3;

endpackage

// File: rtl/tldd_seq_if.sv
// Control/status bundle between the capture sync logic and the pulse sequencer.
interface tldd_seq_if #(
    parameter int unsigned CH_NUM  = 3,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned BURST_W = 8
) ();
    logic               en;
    logic [1:0]         mode;
    logic [CH_NUM-1:0]  ch_mask;
    logic [CNT_W-1:0]   plus_len;
    logic [CNT_W-1:0]   gap_len;
    logic [BURST_W-1:0] burst_num;
    logic               trig;
    logic [CH_NUM-1:0]  ldd_out;
    logic               busy;
    logic               rdy;
    logic               trig_miss;
    logic [BURST_W-1:0] pulse_cnt;

    modport master (
        output en, mode, ch_mask, plus_len, gap_len, burst_num, trig,
        input  ldd_out, busy, rdy, trig_miss, pulse_cnt
    );

    modport slave (
        input  en, mode, ch_mask, plus_len, gap_len, burst_num, trig,
        output ldd_out, busy, rdy, trig_miss, pulse_cnt
    );
endinterface

// File: rtl/tldd_phase_cnt.sv
// Phase down-counter shared by the PULSE and GAP phases. A load of 0 behaves as 1.
module tldd_phase_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clki,
    input  logic             rsti_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] len_i,
    output logic             tc_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load len-1 (0 maps to 0, i.e. a one-cycle phase), else count down and hold at 0.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (len_i == '0) ? '0 : len_i - 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clki or negedge rsti_n) begin
        if (!rsti_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);
endmodule

// File: rtl/tldd_seq.sv
// Multi-channel laser-diode pulse sequencer: single-shot, burst and continuous modes.
module tldd_seq
    import tldd_pkg::*;
#(
    parameter int unsigned CH_NUM  = 3,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned BURST_W = 8
) (
    input logic       clki,
    input logic       rsti_n,
    tldd_seq_if.slave bus
);
    state_e             state_q, state_d;
    logic               trig_d_q;
    logic [CH_NUM-1:0]  mask_q, mask_d;
    logic [CNT_W-1:0]   plen_q, plen_d;
    logic [CNT_W-1:0]   glen_q, glen_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [1:0]         smode_q, smode_d;
    logic [CH_NUM-1:0]  ldd_q, ldd_d;
    logic               busy_q, busy_d;
    logic               rdy_q, rdy_d;
    logic               miss_q, miss_d;
    logic [BURST_W-1:0] pcnt_q, pcnt_d;

    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_len;
    logic               cnt_tc;
    logic               trig_edge;
    logic               trig_mode;
    logic               cont_stop;
    logic [BURST_W-1:0] burst_eff;
    logic               seq_done;

    assign trig_edge = bus.trig & ~trig_d_q;
    assign trig_mode = (bus.mode == MODE_SINGLE) || (bus.mode == MODE_BURST);
    // Continuous runs are the only case where the live mode matters mid-sequence.
    assign cont_stop = (smode_q == MODE_CONT) && (bus.mode != MODE_CONT);
    assign burst_eff = (burst_q == '0) ? BURST_W'(1) : burst_q;
    assign seq_done  = (smode_q == MODE_SINGLE) ||
                       ((smode_q == MODE_BURST) && (pcnt_q == burst_eff)) ||
                       cont_stop;

    tldd_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clki   (clki),
        .rsti_n (rsti_n),
        .load_i (cnt_load),
        .len_i  (cnt_len),
        .tc_o   (cnt_tc)
    );

    // Next-state, shadow latching and registered-output preparation.
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        plen_d   = plen_q;
        glen_d   = glen_q;
        burst_d  = burst_q;
        smode_d  = smode_q;
        pcnt_d   = pcnt_q;
        rdy_d    = 1'b0;
        cnt_load = 1'b0;
        cnt_len  = plen_q;

        if (!bus.en) begin
            // Abort: no rdy, pulse count is kept for inspection.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if ((trig_edge && trig_mode) || (bus.mode == MODE_CONT)) begin
                        state_d  = StPulse;
                        mask_d   = bus.ch_mask;
                        plen_d   = bus.plus_len;
                        glen_d   = bus.gap_len;
                        burst_d  = bus.burst_num;
                        smode_d  = bus.mode;
                        pcnt_d   = BURST_W'(1);
                        cnt_load = 1'b1;
                        cnt_len  = bus.plus_len;
                    end
                end
                StPulse: begin
                    if (cnt_tc) begin
                        if (seq_done) begin
                            state_d = StIdle;
                            rdy_d   = 1'b1;
                        end else begin
                            state_d  = StGap;
                            cnt_load = 1'b1;
                            cnt_len  = glen_q;
                        end
                    end
                end
                StGap: begin
                    if (cnt_tc) begin
                        if (cont_stop) begin
                            state_d = StIdle;
                            rdy_d   = 1'b1;
                        end else begin
                            state_d  = StPulse;
                            cnt_load = 1'b1;
                            cnt_len  = plen_q;
                            pcnt_d   = pcnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        ldd_d  = (state_d == StPulse) ? mask_d : '0;
        busy_d = (state_d != StIdle);
        miss_d = trig_edge && busy_q && bus.en && trig_mode;
    end

    // State, shadow and output registers.
    always_ff @(posedge clki or negedge rsti_n) begin
        if (!rsti_n) begin
            state_q  <= StIdle;
            trig_d_q <= 1'b0;
            mask_q   <= '0;
            plen_q   <= '0;
            glen_q   <= '0;
            burst_q  <= '0;
            smode_q  <= MODE_OFF;
            ldd_q    <= '0;
            busy_q   <= 1'b0;
            rdy_q    <= 1'b0;
            miss_q   <= 1'b0;
            pcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            trig_d_q <= bus.trig;
            mask_q   <= mask_d;
            plen_q   <= plen_d;
            glen_q   <= glen_d;
            burst_q  <= burst_d;
            smode_q  <= smode_d;
            ldd_q    <= ldd_d;
            busy_q   <= busy_d;
            rdy_q    <= rdy_d;
            miss_q   <= miss_d;
            pcnt_q   <= pcnt_d;
        end
    end

    assign bus.ldd_out   = ldd_q;
    assign bus.busy      = busy_q;
    assign bus.rdy       = rdy_q;
    assign bus.trig_miss = miss_q;
    assign bus.pulse_cnt = pcnt_q;
endmodule

// File: tb/tb_tldd_seq.sv
// Directed bench for tldd_seq with hand-computed per-cycle expectations.
module tb_tldd_seq;
    import tldd_pkg::*;

    localparam int unsigned CH_NUM  = 3;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned BURST_W = 8;

    logic clki   = 1'b0;
    logic rsti_n = 1'b1;

    tldd_seq_if #(
        .CH_NUM  (CH_NUM),
        .CNT_W   (CNT_W),
        .BURST_W (BURST_W)
    ) bus ();

    tldd_seq #(
        .CH_NUM  (CH_NUM),
        .CNT_W   (CNT_W),
        .BURST_W (BURST_W)
    ) u_dut (
        .clki   (clki),
        .rsti_n (rsti_n),
        .bus    (bus)
    );

    always #5 clki = ~clki;

    int n_vec = 0;
    int n_err = 0;
    int cy    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cy, got, exp);
        end
    endtask

    // Advance one cycle; sample and drive 2 ns after the rising edge.
    task automatic step();
        @(posedge clki);
        #2;
        cy++;
    endtask

    function automatic logic [31:0] obs();
        return {26'd0, bus.ldd_out, bus.busy, bus.rdy, bus.trig_miss};
    endfunction

    function automatic logic [31:0] expv(input logic [2:0] l, input logic b, input logic r,
                                         input logic m);
        return {26'd0, l, b, r, m};
    endfunction

    // Trigger edge in cycle 10, optional extra edge giving trig_miss at miss_at.
    // plen/glen/n are the effective (zero-substituted) values.
    task automatic run_seq(input string tag, input logic [2:0] msk, input int plen,
                           input int glen, input int n, input int miss_at);
        int   endc;
        logic inb;
        logic inp;
        endc = 11 + n * plen + (n - 1) * glen;
        cy   = 0;
        for (int i = 0; i < endc + 2; i++) begin
            step();
            inb = (cy >= 11) && (cy < endc);
            inp = inb && (((cy - 11) % (plen + glen)) < plen);
            check(tag, obs(), expv(inp ? msk : 3'b000, inb, cy == endc, cy == miss_at));
            bus.trig = (cy == 10) || (cy == miss_at - 1);
        end
        check({tag, "_cnt"}, 32'(bus.pulse_cnt), 32'(n));
    endtask

    initial begin
        bus.en        = 1'b1;
        bus.mode      = MODE_OFF;
        bus.ch_mask   = '0;
        bus.plus_len  = '0;
        bus.gap_len   = '0;
        bus.burst_num = '0;
        bus.trig      = 1'b0;

        // Reset state.
        #3 rsti_n = 1'b0;
        repeat (2) @(posedge clki);
        #2;
        check("reset_out", obs(), expv(3'b000, 1'b0, 1'b0, 1'b0));
        check("reset_cnt", 32'(bus.pulse_cnt), 32'd0);
        @(negedge clki);
        rsti_n = 1'b1;

        // Single shot.
        bus.mode = MODE_SINGLE; bus.ch_mask = 3'b101;
        bus.plus_len = 5; bus.gap_len = 3; bus.burst_num = 1;
        run_seq("single", 3'b101, 5, 3, 1, 0);

        // Burst of 3 with a missed trigger at cycle 14.
        bus.mode = MODE_BURST; bus.ch_mask = 3'b110;
        bus.plus_len = 2; bus.gap_len = 4; bus.burst_num = 3;
        run_seq("burst", 3'b110, 2, 4, 3, 15);

        // Zero lengths behave as 1.
        bus.mode = MODE_BURST; bus.ch_mask = 3'b011;
        bus.plus_len = 0; bus.gap_len = 0; bus.burst_num = 0;
        run_seq("zero_len", 3'b011, 1, 1, 1, 0);

        // Empty channel mask: full timing, outputs low.
        bus.mode = MODE_BURST; bus.ch_mask = 3'b000;
        bus.plus_len = 3; bus.gap_len = 2; bus.burst_num = 2;
        run_seq("mask0", 3'b000, 3, 2, 2, 0);

        // en dropped during the second pulse of a burst.
        bus.mode = MODE_BURST; bus.ch_mask = 3'b111;
        bus.plus_len = 2; bus.gap_len = 4; bus.burst_num = 3;
        cy = 0;
        repeat (17) begin
            step();
            bus.trig = (cy == 10);
        end
        check("en_pulse2", obs(), expv(3'b111, 1'b1, 1'b0, 1'b0));
        bus.en = 1'b0;
        step();
        check("en_abort", obs(), expv(3'b000, 1'b0, 1'b0, 1'b0));
        check("en_abort_cnt", 32'(bus.pulse_cnt), 32'd2);
        step();
        check("en_idle", obs(), expv(3'b000, 1'b0, 1'b0, 1'b0));
        bus.en = 1'b1;

        // Async reset mid-pulse, then a normal shot.
        bus.mode = MODE_SINGLE; bus.ch_mask = 3'b101;
        bus.plus_len = 5; bus.gap_len = 3; bus.burst_num = 1;
        cy = 0;
        repeat (12) begin
            step();
            bus.trig = (cy == 10);
        end
        check("rst_pre", obs(), expv(3'b101, 1'b1, 1'b0, 1'b0));
        #1 rsti_n = 1'b0;
        #1;
        check("rst_async", obs(), expv(3'b000, 1'b0, 1'b0, 1'b0));
        check("rst_async_cnt", 32'(bus.pulse_cnt), 32'd0);
        @(negedge clki);
        rsti_n = 1'b1;
        run_seq("post_rst", 3'b101, 5, 3, 1, 0);

        // Continuous, 1/1 timing, wrap of pulse_cnt and stop via mode change.
        bus.mode = MODE_OFF; bus.ch_mask = 3'b100;
        bus.plus_len = 1; bus.gap_len = 1; bus.burst_num = 0;
        step();
        cy = 0;
        bus.mode = MODE_CONT;
        repeat (8) begin
            step();
            check("cont_out", obs(), expv(cy[0] ? 3'b100 : 3'b000, 1'b1, 1'b0, 1'b0));
            check("cont_cnt", 32'(bus.pulse_cnt), 32'((cy + 1) / 2));
        end
        while (cy < 509) step();
        check("cont_255_out", obs(), expv(3'b100, 1'b1, 1'b0, 1'b0));
        check("cont_255_cnt", 32'(bus.pulse_cnt), 32'd255);
        step();
        step();
        check("cont_wrap_cnt", 32'(bus.pulse_cnt), 32'd0);
        step();
        step();
        check("cont_last_out", obs(), expv(3'b100, 1'b1, 1'b0, 1'b0));
        check("cont_last_cnt", 32'(bus.pulse_cnt), 32'd1);
        bus.mode = MODE_SINGLE;
        step();
        check("cont_stop", obs(), expv(3'b000, 1'b0, 1'b1, 1'b0));
        step();
        check("cont_idle", obs(), expv(3'b000, 1'b0, 1'b0, 1'b0));
        check("cont_idle_cnt", 32'(bus.pulse_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
